// File: rtl/codec_i2c_sequencer.sv
// ============================================================================
// Module   : codec_i2c_sequencer
// Purpose  : Shares one I2C controller between the software register path
//            and a hardware sequencer that programs the CODEC sample rate and
//            activation. Transactions are serialized; status goes back to
//            whichever requester owns the current transaction.
// Ports    : board_clk/resetn        - clock, async active-low reset
//            ctrl_init_done           - controller ready (arbitration gate)
//            apply_config/frequency   - start a config sequence
//            cfg_busy/done/error      - config sequence status
//            sw_wr_req/sw_rd_req/...  - software request and response
//            ctrl_*                   - controller_unit_top interface
// Options  : CODEC_CFG_READBACK_EN - read back each config write and compare
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module codec_i2c_sequencer #(
  parameter int         BUSY_TIMEOUT = 1024,
  parameter logic [7:0] ADDR_ACTIVE  = 8'h09,
  parameter logic [7:0] ADDR_SRATE   = 8'h08
) (
  input  logic       board_clk,
  input  logic       resetn,
  input  logic       ctrl_init_done,
  input  logic       apply_config,
  input  logic [2:0] frequency,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error,
  input  logic       sw_wr_req,
  input  logic       sw_rd_req,
  input  logic [7:0] sw_addr,
  input  logic [8:0] sw_wdata,
  output logic       sw_ack,
  output logic [8:0] sw_rd_data,
  output logic       sw_err,
  output logic       ctrl_wr_en,
  output logic       ctrl_rd_en,
  output logic [7:0] ctrl_reg_addr,
  output logic [8:0] ctrl_data_in,
  input  logic       ctrl_busy,
  input  logic [8:0] ctrl_data_out,
  input  logic       ctrl_data_out_valid,
  input  logic       ctrl_missed_ack
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_HI  = 3'd2,
    S_WAIT_LO  = 3'd3,
    S_COMPLETE = 3'd4
  } state_t;

  localparam logic [15:0] C_TMO = BUSY_TIMEOUT[15:0];

`ifdef CODEC_CFG_READBACK_EN
  localparam logic [2:0] C_CFG_LAST = 3'd5;
`else
  localparam logic [2:0] C_CFG_LAST = 3'd2;
`endif

  // SRATE register value for each supported sample rate.
  function automatic logic [8:0] f_srate(input logic [2:0] f);
    case (f)
      3'd0:    f_srate = 9'h000;
      3'd1:    f_srate = 9'h020;
      3'd2:    f_srate = 9'h018;
      3'd3:    f_srate = 9'h00C;
      default: f_srate = 9'h01C;
    endcase
  endfunction

  // Config step -> {is_read, addr, data}. For reads, data is the value the
  // readback must match.
  function automatic logic [17:0] f_step(input logic [2:0] idx, input logic [8:0] srate);
`ifdef CODEC_CFG_READBACK_EN
    case (idx)
      3'd0:    f_step = {1'b0, ADDR_ACTIVE, 9'h000};
      3'd1:    f_step = {1'b1, ADDR_ACTIVE, 9'h000};
      3'd2:    f_step = {1'b0, ADDR_SRATE,  srate};
      3'd3:    f_step = {1'b1, ADDR_SRATE,  srate};
      3'd4:    f_step = {1'b0, ADDR_ACTIVE, 9'h001};
      default: f_step = {1'b1, ADDR_ACTIVE, 9'h001};
    endcase
`else
    case (idx)
      3'd0:    f_step = {1'b0, ADDR_ACTIVE, 9'h000};
      3'd1:    f_step = {1'b0, ADDR_SRATE,  srate};
      default: f_step = {1'b0, ADDR_ACTIVE, 9'h001};
    endcase
`endif
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_cfg_pend, r_cfg_active, r_cfg_err, r_bad_done;
  logic [2:0]  r_freq, r_idx;
  logic [8:0]  r_srate;
  logic        r_is_cfg, r_is_rd, r_err, r_sw_block;
  logic [7:0]  r_addr;
  logic [8:0]  r_wdata, r_rdata;
  logic [15:0] r_cnt;

  logic        w_apply_ok, w_apply_bad, w_cfg_req;
  logic [2:0]  w_freq_sel;
  logic [8:0]  w_srate_sel;
  logic        w_sw_wr, w_sw_rd, w_arb;
  logic        w_grant_cfg, w_grant_wr, w_grant_rd;
  logic        w_timeout, w_rb_bad, w_fail, w_cfg_end, w_cfg_next;
  logic [17:0] w_step0, w_step_nxt;
  logic        w_req_on, w_sw_ack, w_cfg_done;

  assign w_apply_ok  = apply_config & ~r_cfg_active & (frequency <= 3'd4);
  assign w_apply_bad = apply_config & ~r_cfg_active & (frequency >  3'd4);
  // A same-cycle apply_config must beat a software request, so the live
  // pulse counts as pending before it has been registered.
  assign w_cfg_req   = r_cfg_pend | w_apply_ok;
  assign w_freq_sel  = w_apply_ok ? frequency : r_freq;
  assign w_srate_sel = f_srate(w_freq_sel);

  // The cycle right after sw_ack ignores software requests: the requester
  // is still dropping the one just acknowledged.
  assign w_sw_wr     = sw_wr_req & ~r_sw_block;
  assign w_sw_rd     = sw_rd_req & ~r_sw_block;
  assign w_arb       = (r_state == S_IDLE) & ctrl_init_done;
  assign w_grant_cfg = w_arb & w_cfg_req;
  assign w_grant_wr  = w_arb & ~w_cfg_req & w_sw_wr;
  assign w_grant_rd  = w_arb & ~w_cfg_req & ~w_sw_wr & w_sw_rd;

  // Fires on the last cycle the request is held, so the request is high
  // for exactly BUSY_TIMEOUT cycles counting ISSUE.
  assign w_timeout   = ({1'b0, r_cnt} + 17'd1) >= {1'b0, C_TMO};

`ifdef CODEC_CFG_READBACK_EN
  assign w_rb_bad    = r_is_cfg & r_is_rd & (r_rdata != r_wdata);
`else
  assign w_rb_bad    = 1'b0;
`endif
  assign w_fail      = r_err | w_rb_bad;
  assign w_cfg_end   = (r_state == S_COMPLETE) & r_is_cfg & (w_fail | (r_idx == C_CFG_LAST));
  assign w_cfg_next  = (r_state == S_COMPLETE) & r_is_cfg & ~w_fail & (r_idx != C_CFG_LAST);
  assign w_step0     = f_step(3'd0, w_srate_sel);
  assign w_step_nxt  = f_step(r_idx + 3'd1, r_srate);

  always_comb begin
    w_state_nxt = r_state;
    w_req_on    = 1'b0;
    w_sw_ack    = 1'b0;
    w_cfg_done  = r_bad_done;
    case (r_state)
      S_IDLE: begin
        if (w_grant_cfg | w_grant_wr | w_grant_rd) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_req_on    = 1'b1;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        w_req_on = 1'b1;
        if (ctrl_busy)      w_state_nxt = S_WAIT_LO;
        else if (w_timeout) w_state_nxt = S_COMPLETE;
      end
      S_WAIT_LO: begin
        if (!ctrl_busy) w_state_nxt = S_COMPLETE;
      end
      S_COMPLETE: begin
        if (r_is_cfg) begin
          w_cfg_done  = w_cfg_done | w_cfg_end;
          w_state_nxt = w_cfg_next ? S_ISSUE : S_IDLE;
        end else begin
          w_sw_ack    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge board_clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cfg_pend   <= 1'b0;
      r_cfg_active <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_bad_done   <= 1'b0;
      r_freq       <= 3'd0;
      r_idx        <= 3'd0;
      r_srate      <= 9'd0;
      r_is_cfg     <= 1'b0;
      r_is_rd      <= 1'b0;
      r_err        <= 1'b0;
      r_sw_block   <= 1'b0;
      r_addr       <= 8'd0;
      r_wdata      <= 9'd0;
      r_rdata      <= 9'd0;
      r_cnt        <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_bad_done <= w_apply_bad;
      r_sw_block <= (r_state == S_COMPLETE) & ~r_is_cfg;

      if (w_apply_ok | w_apply_bad)  r_cfg_err <= w_apply_bad;
      else if (w_cfg_end & w_fail)   r_cfg_err <= 1'b1;

      if (w_apply_ok) r_freq <= frequency;
      if (w_grant_cfg)     r_cfg_pend <= 1'b0;
      else if (w_apply_ok) r_cfg_pend <= 1'b1;

      if (w_grant_cfg)    r_cfg_active <= 1'b1;
      else if (w_cfg_end) r_cfg_active <= 1'b0;

      if (w_grant_cfg) begin
        r_is_cfg                    <= 1'b1;
        r_idx                       <= 3'd0;
        r_srate                     <= w_srate_sel;
        {r_is_rd, r_addr, r_wdata}  <= w_step0;
      end else if (w_grant_wr | w_grant_rd) begin
        r_is_cfg <= 1'b0;
        r_is_rd  <= w_grant_rd;
        r_addr   <= sw_addr;
        r_wdata  <= sw_wdata;
      end else if (w_cfg_next) begin
        r_idx                       <= r_idx + 3'd1;
        {r_is_rd, r_addr, r_wdata}  <= w_step_nxt;
      end

      if ((w_state_nxt == S_ISSUE) && (r_state != S_ISSUE)) begin
        r_cnt   <= 16'd0;
        r_err   <= 1'b0;
        r_rdata <= 9'd0;
      end else begin
        if (((r_state == S_ISSUE) || (r_state == S_WAIT_HI)) && (r_cnt != 16'hFFFF))
          r_cnt <= r_cnt + 16'd1;
        if ((r_state == S_WAIT_HI) && !ctrl_busy && w_timeout)
          r_err <= 1'b1;
        if ((r_state == S_WAIT_HI) || (r_state == S_WAIT_LO)) begin
          if (ctrl_busy && ctrl_missed_ack) r_err   <= 1'b1;
          if (ctrl_data_out_valid)          r_rdata <= ctrl_data_out;
        end
      end
    end
  end

  // Request lines come straight from state so they drop with the async reset.
  assign ctrl_wr_en    = w_req_on & ~r_is_rd;
  assign ctrl_rd_en    = w_req_on &  r_is_rd;
  assign ctrl_reg_addr = r_addr;
  assign ctrl_data_in  = r_wdata;
  assign cfg_busy      = r_cfg_active;
  assign cfg_done      = w_cfg_done;
  assign cfg_error     = r_cfg_err;
  assign sw_ack        = w_sw_ack;
  assign sw_err        = w_sw_ack & r_err;
  assign sw_rd_data    = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_codec_i2c_sequencer.sv
// ============================================================================
// Module   : tb_codec_i2c_sequencer
// Purpose  : Scoreboard bench for codec_i2c_sequencer with a behavioural
//            I2C controller model (normal / missed-ack / never-busy).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_codec_i2c_sequencer;

  logic       board_clk = 1'b0;
  logic       resetn, ctrl_init_done, apply_config;
  logic [2:0] frequency;
  logic       cfg_busy, cfg_done, cfg_error;
  logic       sw_wr_req, sw_rd_req;
  logic [7:0] sw_addr;
  logic [8:0] sw_wdata;
  logic       sw_ack, sw_err;
  logic [8:0] sw_rd_data;
  logic       ctrl_wr_en, ctrl_rd_en;
  logic [7:0] ctrl_reg_addr;
  logic [8:0] ctrl_data_in;
  logic       ctrl_busy, ctrl_data_out_valid, ctrl_missed_ack;
  logic [8:0] ctrl_data_out;

  always #10 board_clk = ~board_clk;

  codec_i2c_sequencer u_dut (
    .board_clk           (board_clk),
    .resetn              (resetn),
    .ctrl_init_done      (ctrl_init_done),
    .apply_config        (apply_config),
    .frequency           (frequency),
    .cfg_busy            (cfg_busy),
    .cfg_done            (cfg_done),
    .cfg_error           (cfg_error),
    .sw_wr_req           (sw_wr_req),
    .sw_rd_req           (sw_rd_req),
    .sw_addr             (sw_addr),
    .sw_wdata            (sw_wdata),
    .sw_ack              (sw_ack),
    .sw_rd_data          (sw_rd_data),
    .sw_err              (sw_err),
    .ctrl_wr_en          (ctrl_wr_en),
    .ctrl_rd_en          (ctrl_rd_en),
    .ctrl_reg_addr       (ctrl_reg_addr),
    .ctrl_data_in        (ctrl_data_in),
    .ctrl_busy           (ctrl_busy),
    .ctrl_data_out       (ctrl_data_out),
    .ctrl_data_out_valid (ctrl_data_out_valid),
    .ctrl_missed_ack     (ctrl_missed_ack)
  );

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [8:0] data;
    logic       cfg;
  } txn_t;

  typedef struct packed {
    logic       chk_rd;
    logic [8:0] rdata;
    logic       err;
  } swr_t;

  txn_t exp_txn[$];
  swr_t exp_sw[$];
  logic exp_cfg[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- controller model ----------------
  int         mode;      // 0 normal, 1 missed ack, 2 never busy
  logic [8:0] rd_value;  // returned for reads of non-CODEC-config addresses
  logic [8:0] mem [0:255];
  int         m_st, m_cnt;
  logic       m_rd;
  logic [7:0] m_addr;

  always @(posedge board_clk or negedge resetn) begin
    if (!resetn) begin
      m_st                <= 0;
      m_cnt               <= 0;
      ctrl_busy           <= 1'b0;
      ctrl_data_out_valid <= 1'b0;
      ctrl_missed_ack     <= 1'b0;
      ctrl_data_out       <= 9'd0;
    end else begin
      ctrl_data_out_valid <= 1'b0;
      ctrl_missed_ack     <= 1'b0;
      case (m_st)
        0: if ((ctrl_wr_en || ctrl_rd_en) && mode != 2) begin
             m_st   <= 1;
             m_rd   <= ctrl_rd_en;
             m_addr <= ctrl_reg_addr;
             if (ctrl_wr_en) mem[ctrl_reg_addr] <= ctrl_data_in;
           end
        1: begin ctrl_busy <= 1'b1; m_cnt <= 0; m_st <= 2; end
        default: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt == 5 && mode == 1) ctrl_missed_ack <= 1'b1;
          if (m_cnt == 10 && m_rd) begin
            ctrl_data_out       <= (m_addr == 8'h08 || m_addr == 8'h09) ? mem[m_addr] : rd_value;
            ctrl_data_out_valid <= 1'b1;
          end
          if (m_cnt == 19) begin ctrl_busy <= 1'b0; m_st <= 0; end
        end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic m_req;
  assign m_req = ctrl_wr_en | ctrl_rd_en;
  logic m_prev_req = 1'b0;
  int   hi_len = 0, last_hi_len = 0, n_txn = 0;
  logic chk_err_pend = 1'b0, exp_err_nxt = 1'b0;

  always @(negedge board_clk) begin
    if (m_req && !m_prev_req) begin
      n_txn <= n_txn + 1;
      if (exp_txn.size() == 0) check("unexpected_txn", 32'(exp_txn.size()), 32'd1);
      else begin
        check("txn_rd",       ctrl_rd_en,    exp_txn[0].rd);
        check("txn_addr",     ctrl_reg_addr, exp_txn[0].addr);
        if (!exp_txn[0].rd) check("txn_data", ctrl_data_in, exp_txn[0].data);
        check("txn_cfg_busy", cfg_busy,      exp_txn[0].cfg);
        exp_txn.delete(0);
      end
    end
    hi_len <= m_req ? hi_len + 1 : 0;
    if (!m_req && m_prev_req) last_hi_len <= hi_len;
    m_prev_req <= m_req;

    if (sw_ack) begin
      if (exp_sw.size() == 0) check("unexpected_sw_ack", 32'(exp_sw.size()), 32'd1);
      else begin
        check("sw_err", sw_err, exp_sw[0].err);
        if (exp_sw[0].chk_rd) check("sw_rd_data", sw_rd_data, exp_sw[0].rdata);
        exp_sw.delete(0);
      end
    end

    if (chk_err_pend) check("cfg_error", cfg_error, exp_err_nxt);
    chk_err_pend <= 1'b0;
    if (cfg_done) begin
      if (exp_cfg.size() == 0) check("unexpected_cfg_done", 32'(exp_cfg.size()), 32'd1);
      else begin
        exp_err_nxt  <= exp_cfg[0];
        chk_err_pend <= 1'b1;
        exp_cfg.delete(0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic txn_t mk(input logic rd, input logic [7:0] a, input logic [8:0] d, input logic c);
    txn_t t;
    t.rd = rd; t.addr = a; t.data = d; t.cfg = c;
    return t;
  endfunction

  function automatic logic [8:0] srate_of(input logic [2:0] f);
    case (f)
      3'd0: return 9'h000;
      3'd1: return 9'h020;
      3'd2: return 9'h018;
      3'd3: return 9'h00C;
      default: return 9'h01C;
    endcase
  endfunction

  task automatic push_cfg(input logic [2:0] f);
    logic [7:0] a [3];
    logic [8:0] d [3];
    a[0] = 8'h09; d[0] = 9'h000;
    a[1] = 8'h08; d[1] = srate_of(f);
    a[2] = 8'h09; d[2] = 9'h001;
    for (int i = 0; i < 3; i++) begin
      exp_txn.push_back(mk(1'b0, a[i], d[i], 1'b1));
`ifdef CODEC_CFG_READBACK_EN
      exp_txn.push_back(mk(1'b1, a[i], d[i], 1'b1));
`endif
    end
    exp_cfg.push_back(1'b0);
  endtask

  task automatic apply(input logic [2:0] f);
    @(negedge board_clk);
    apply_config = 1'b1;
    frequency    = f;
    @(negedge board_clk);
    apply_config = 1'b0;
  endtask

  task automatic wait_cfg_done(input string tag, input int maxc);
    int k = 0;
    while (!cfg_done && k < maxc) begin @(negedge board_clk); k++; end
    if (!cfg_done) check(tag, cfg_done, 1'b1);
    @(negedge board_clk);
  endtask

  task automatic wait_ack_drop(input string tag, input int maxc);
    int k = 0;
    while (!sw_ack && k < maxc) begin @(negedge board_clk); k++; end
    if (!sw_ack) check(tag, sw_ack, 1'b1);
    sw_wr_req = 1'b0;
    sw_rd_req = 1'b0;
    @(negedge board_clk);
  endtask

  task automatic sw_txn(input logic rd, input logic [7:0] a, input logic [8:0] d,
                        input logic e_err, input logic [8:0] e_rd, input int maxc);
    exp_txn.push_back(mk(rd, a, d, 1'b0));
    exp_sw.push_back('{chk_rd: rd, rdata: e_rd, err: e_err});
    @(negedge board_clk);
    sw_addr  = a;
    sw_wdata = d;
    if (rd) sw_rd_req = 1'b1; else sw_wr_req = 1'b1;
    wait_ack_drop(rd ? "sw_rd_ack_timeout" : "sw_wr_ack_timeout", maxc);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, tgt, k;
    resetn = 1'b0; ctrl_init_done = 1'b0; apply_config = 1'b0; frequency = 3'd0;
    sw_wr_req = 1'b0; sw_rd_req = 1'b0; sw_addr = 8'd0; sw_wdata = 9'd0;
    mode = 0; rd_value = 9'h0A5;

    repeat (3) @(negedge board_clk);
    check("rst_cfg_busy",  cfg_busy,      1'b0);
    check("rst_cfg_done",  cfg_done,      1'b0);
    check("rst_cfg_error", cfg_error,     1'b0);
    check("rst_sw_ack",    sw_ack,        1'b0);
    check("rst_sw_err",    sw_err,        1'b0);
    check("rst_sw_rd",     sw_rd_data,    9'd0);
    check("rst_wr_en",     ctrl_wr_en,    1'b0);
    check("rst_rd_en",     ctrl_rd_en,    1'b0);
    check("rst_addr",      ctrl_reg_addr, 8'd0);
    check("rst_data",      ctrl_data_in,  9'd0);
    resetn = 1'b1;

    // Config held off while the controller is not initialised.
    push_cfg(3'd1);
    apply(3'd1);
    repeat (30) @(negedge board_clk);
    check("gated_cfg_busy", cfg_busy, 1'b0);
    check("gated_no_txn",   32'(exp_txn.size()), 32'(3 * (`ifdef CODEC_CFG_READBACK_EN 2 `else 1 `endif)));
    ctrl_init_done = 1'b1;
    wait_cfg_done("t1_cfg_done_timeout", 600);
    check("t1_busy_after", cfg_busy, 1'b0);

    // Unsupported rate: immediate done with error, no traffic.
    exp_cfg.push_back(1'b1);
    apply(3'd6);
    wait_cfg_done("t2_cfg_done_timeout", 3);
    check("t2_err_sticky", cfg_error, 1'b1);
    push_cfg(3'd4);
    apply(3'd4);
    repeat (3) @(negedge board_clk);
    check("t2_err_cleared", cfg_error, 1'b0);
    wait_cfg_done("t2b_cfg_done_timeout", 600);

    // Simultaneous config and software write: config first.
    push_cfg(3'd0);
    exp_txn.push_back(mk(1'b0, 8'h05, 9'h1AB, 1'b0));
    exp_sw.push_back('{chk_rd: 1'b0, rdata: 9'd0, err: 1'b0});
    @(negedge board_clk);
    apply_config = 1'b1; frequency = 3'd0;
    sw_wr_req = 1'b1; sw_addr = 8'h05; sw_wdata = 9'h1AB;
    @(negedge board_clk);
    apply_config = 1'b0;
    wait_ack_drop("t3_ack_timeout", 900);

    // Software read, then missed ack.
    sw_txn(1'b1, 8'h07, 9'h000, 1'b0, 9'h0A5, 200);
    mode = 1;
    sw_txn(1'b0, 8'h03, 9'h055, 1'b1, 9'h000, 200);
    mode = 0;

    // Controller never busy: software then config timeout.
    mode = 2;
    sw_txn(1'b0, 8'h11, 9'h123, 1'b1, 9'h000, 1200);
    check("t5_tmo_len", (last_hi_len >= 1024 && last_hi_len <= 1026) ? 32'd1024 : 32'(last_hi_len), 32'd1024);
    exp_txn.push_back(mk(1'b0, 8'h09, 9'h000, 1'b1));
    exp_cfg.push_back(1'b1);
    apply(3'd0);
    wait_cfg_done("t5_cfg_done_timeout", 1200);
    mode = 0;
    check("t5_busy_after", cfg_busy, 1'b0);
    sw_txn(1'b1, 8'h20, 9'h000, 1'b0, 9'h0A5, 200);

    // Reset during WAIT_LO of config write 2.
    base = n_txn;
    tgt  = `ifdef CODEC_CFG_READBACK_EN 3 `else 2 `endif;
    push_cfg(3'd2);
    apply(3'd2);
    k = 0;
    while (!((n_txn - base) == tgt && ctrl_busy && !m_req) && k < 300) begin @(negedge board_clk); k++; end
    check("t6_reached_wait_lo", 32'(n_txn - base), 32'(tgt));
    repeat (4) @(negedge board_clk);
    #3 resetn = 1'b0;
    #1;
    check("t6_wr_en_drop", ctrl_wr_en, 1'b0);
    check("t6_rd_en_drop", ctrl_rd_en, 1'b0);
    check("t6_cfg_busy",   cfg_busy,   1'b0);
    exp_txn.delete();
    exp_cfg.delete();
    @(negedge board_clk);
    resetn = 1'b1;
    repeat (30) @(negedge board_clk);
    check("t6_idle_busy", cfg_busy, 1'b0);
    push_cfg(3'd3);
    apply(3'd3);
    wait_cfg_done("t6_cfg_done_timeout", 600);

    repeat (5) @(negedge board_clk);
    check("end_txn_queue", 32'(exp_txn.size()), 32'd0);
    check("end_sw_queue",  32'(exp_sw.size()),  32'd0);
    check("end_cfg_queue", 32'(exp_cfg.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
